bram_ddr_resp: RTL and testbench

//  Responder end of the wstart/wready/rstart/rready user DMA interface; drop-in stand-in for the DDR4 path.

---
 rtl/ku_pkg.sv | 22 ++
 rtl/sdp_ram.sv | 34 +++
 rtl/bram_ddr_resp.sv | 176 +++++++++++++++++
 tb/tb_bram_ddr_resp.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ku_pkg.sv
// Shared definitions for the BRAM-backed DMA responder: width defaults, FSM state
// encodings and the byte-offset shift helper.
package ku_pkg;

  localparam int DATA_WIDTH_DEF = 64;
  localparam int ADDR_WIDTH_DEF = 32;
  localparam int LEN_WIDTH_DEF  = 16;
  localparam int MEM_DEPTH_DEF  = 4096;

  localparam logic [0:0] W_IDLE  = 1'b0;
  localparam logic [0:0] W_DATA  = 1'b1;

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_RUN   = 2'd1;
  localparam logic [1:0] R_DRAIN = 2'd2;

  // Number of byte-offset bits inside one beat.
  function automatic int byte_shift(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port and one registered read port.
// A read and a write to the same index in one cycle return the old data.
module sdp_ram #(
  parameter int DATA_WIDTH = 64,
  parameter int MEM_DEPTH  = 4096
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         we,
  input  logic [$clog2(MEM_DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic                         re,
  input  logic                         rclr,
  input  logic [$clog2(MEM_DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]        rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; only the output register is reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // rclr returns zero for beats that fall outside the valid window.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= rclr ? '0 : mem[raddr];
    end
  end

endmodule

// File: rtl/bram_ddr_resp.sv
// Responder for the wstart/wready/rstart/rready DMA interface, served from on-chip BRAM.
// Optional macro BRAM_DDR_RESP_BOUND_CHK_EN: flag and suppress accesses beyond MEM_DEPTH instead of wrapping.
module bram_ddr_resp
  import ku_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int LEN_WIDTH  = LEN_WIDTH_DEF,
  parameter int MEM_DEPTH  = MEM_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wstart,
  output logic                  wready,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [LEN_WIDTH-1:0]  wdata_len,
  input  logic                  wdata_vld,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rstart,
  output logic                  rready,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic [LEN_WIDTH-1:0]  rdata_len,
  output logic                  rdata_vld,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  bound_err
);

  localparam int SHIFT = byte_shift(DATA_WIDTH);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  // Extended index is wide enough that start_idx+len never overflows.
  localparam int EXT_W = ((IDX_W > LEN_WIDTH) ? IDX_W : LEN_WIDTH) + 1;

  logic [0:0]           w_state;
  logic [EXT_W-1:0]     w_idx;
  logic [LEN_WIDTH-1:0] w_len;
  logic [LEN_WIDTH-1:0] w_cnt;
  logic [IDX_W-1:0]     w_start_idx;
  logic                 w_accept;
  logic                 w_beat;
  logic                 w_last;
  logic                 w_in_range;

  logic [1:0]           r_state;
  logic [EXT_W-1:0]     r_idx;
  logic [LEN_WIDTH-1:0] r_len;
  logic [LEN_WIDTH-1:0] r_cnt;
  logic [IDX_W-1:0]     r_start_idx;
  logic                 r_accept;
  logic                 r_issue;
  logic                 r_last_issue;
  logic                 r_in_range;

  logic                 addr_unused;

  assign w_start_idx  = waddr[SHIFT +: IDX_W];
  assign w_accept     = wstart && wready && (wdata_len != '0);
  assign w_beat       = (w_state == W_DATA) && wdata_vld;
  assign w_last       = w_beat && (w_cnt == w_len - LEN_WIDTH'(1));

  assign r_start_idx  = raddr[SHIFT +: IDX_W];
  assign r_accept     = rstart && rready && (rdata_len != '0);
  assign r_issue      = (r_state == R_RUN);
  assign r_last_issue = r_issue && (r_cnt == r_len - LEN_WIDTH'(1));

  // Byte-offset and above-depth address bits are intentionally ignored.
  assign addr_unused  = ^{waddr, raddr, w_idx, r_idx};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state <= W_IDLE;
      wready  <= 1'b0;
      w_idx   <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          wready <= 1'b1;
          if (w_accept) begin
            w_state <= W_DATA;
            wready  <= 1'b0;
            w_idx   <= EXT_W'(w_start_idx);
            w_len   <= wdata_len;
            w_cnt   <= '0;
          end
        end
        default: begin
          if (w_beat) begin
            w_idx <= w_idx + EXT_W'(1);
            w_cnt <= w_cnt + LEN_WIDTH'(1);
            if (w_last) begin
              w_state <= W_IDLE;
              wready  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  // rdata_vld tracks the one-cycle latency of the RAM read port.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= R_IDLE;
      rready    <= 1'b0;
      rdata_vld <= 1'b0;
      r_idx     <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
    end else begin
      rdata_vld <= r_issue;
      case (r_state)
        R_IDLE: begin
          rready <= 1'b1;
          if (r_accept) begin
            r_state <= R_RUN;
            rready  <= 1'b0;
            r_idx   <= EXT_W'(r_start_idx);
            r_len   <= rdata_len;
            r_cnt   <= '0;
          end
        end
        R_RUN: begin
          r_idx <= r_idx + EXT_W'(1);
          r_cnt <= r_cnt + LEN_WIDTH'(1);
          if (r_last_issue) r_state <= R_DRAIN;
        end
        R_DRAIN: begin
          if (rdata_vld) begin
            r_state <= R_IDLE;
            rready  <= 1'b1;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

`ifdef BRAM_DDR_RESP_BOUND_CHK_EN
  logic w_oob;
  logic r_oob;

  assign w_oob      = (EXT_W'(w_start_idx) + EXT_W'(wdata_len)) > EXT_W'(MEM_DEPTH);
  assign r_oob      = (EXT_W'(r_start_idx) + EXT_W'(rdata_len)) > EXT_W'(MEM_DEPTH);
  assign w_in_range = (w_idx < EXT_W'(MEM_DEPTH));
  assign r_in_range = (r_idx < EXT_W'(MEM_DEPTH));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bound_err <= 1'b0;
    end else if ((w_accept && w_oob) || (r_accept && r_oob)) begin
      bound_err <= 1'b1;
    end
  end
`else
  assign w_in_range = 1'b1;
  assign r_in_range = 1'b1;
  assign bound_err  = 1'b0;
`endif

  sdp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_ram (
    .clk   (clk),
    .rstn  (rstn),
    .we    (w_beat && w_in_range),
    .waddr (w_idx[IDX_W-1:0]),
    .wdata (wdata),
    .re    (r_issue),
    .rclr  (!r_in_range),
    .raddr (r_idx[IDX_W-1:0]),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_bram_ddr_resp.sv
// Self-checking bench for bram_ddr_resp (MEM_DEPTH=16) against a queue/array reference model.
// Honours BRAM_DDR_RESP_BOUND_CHK_EN when the macro is defined for the build.
module tb_bram_ddr_resp;

  localparam int DW    = 64;
  localparam int AW    = 32;
  localparam int LW    = 16;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          wstart = 1'b0;
  logic          wready;
  logic [AW-1:0] waddr = '0;
  logic [LW-1:0] wdata_len = '0;
  logic          wdata_vld = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic          rstart = 1'b0;
  logic          rready;
  logic [AW-1:0] raddr = '0;
  logic [LW-1:0] rdata_len = '0;
  logic          rdata_vld;
  logic [DW-1:0] rdata;
  logic          bound_err;

  bram_ddr_resp #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .LEN_WIDTH  (LW),
    .MEM_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .wstart    (wstart),
    .wready    (wready),
    .waddr     (waddr),
    .wdata_len (wdata_len),
    .wdata_vld (wdata_vld),
    .wdata     (wdata),
    .rstart    (rstart),
    .rready    (rready),
    .raddr     (raddr),
    .rdata_len (rdata_len),
    .rdata_vld (rdata_vld),
    .rdata     (rdata),
    .bound_err (bound_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int unsigned   cyc;
    logic [DW-1:0] data;
  } beat_t;

  logic [DW-1:0] mem_m [DEPTH];
  beat_t         exp_q[$];
  logic [DW-1:0] cap_q[$];
  logic [DW-1:0] last_exp = '0;
  logic          exp_bound = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int start_of(input logic [AW-1:0] a);
    return int'((a >> 3) % DEPTH);
  endfunction

  function automatic bit in_range(input int s, input int k);
`ifdef BRAM_DDR_RESP_BOUND_CHK_EN
    return (s + k) < DEPTH;
`else
    return 1'b1;
`endif
  endfunction

  function automatic void note_bound(input int s, input int len);
`ifdef BRAM_DDR_RESP_BOUND_CHK_EN
    if (len != 0 && s + len > DEPTH) exp_bound = 1'b1;
`endif
  endfunction

  // Read-channel compare: every cycle rdata_vld/rdata must match the scheduled beats.
  always @(negedge clk) begin
    if (!rstn) begin
      check("rst_rdata_vld", 64'(rdata_vld), 64'd0);
      check("rst_rdata", rdata, 64'd0);
    end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      check("rd_vld", 64'(rdata_vld), 64'd1);
      check("rd_data", rdata, exp_q[0].data);
      last_exp = exp_q[0].data;
      cap_q.push_back(rdata);
      void'(exp_q.pop_front());
    end else begin
      check("idle_rdata_vld", 64'(rdata_vld), 64'd0);
      check("hold_rdata", rdata, last_exp);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input int len, input int gap_pct,
                          input logic [DW-1:0] base, input bit rnd);
    int t = 0;
    int s;
    logic [DW-1:0] d;
    while (!wready && t < 200) begin
      step();
      t++;
    end
    check("wready_wait", 64'(wready), 64'd1);
    s = start_of(addr);
    note_bound(s, len);
    wstart    = 1'b1;
    waddr     = addr;
    wdata_len = LW'(len);
    step();
    wstart = 1'b0;
    if (len == 0) begin
      repeat (3) begin
        check("w_len0_ready", 64'(wready), 64'd1);
        step();
      end
      return;
    end
    for (int k = 0; k < len; k++) begin
      if ($urandom_range(99) < gap_pct) begin
        wdata_vld = 1'b0;
        check("w_busy_gap", 64'(wready), 64'd0);
        step();
      end
      d = rnd ? {$urandom, $urandom} : base + DW'(k);
      wdata_vld = 1'b1;
      wdata     = d;
      check("w_busy", 64'(wready), 64'd0);
      if (in_range(s, k)) mem_m[(s + k) % DEPTH] = d;
      step();
    end
    wdata_vld = 1'b0;
    check("w_done_ready", 64'(wready), 64'd1);
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input int len);
    int t = 0;
    int s;
    int unsigned n;
    beat_t b;
    while (!rready && t < 200) begin
      step();
      t++;
    end
    check("rready_wait", 64'(rready), 64'd1);
    s = start_of(addr);
    n = cyc;
    note_bound(s, len);
    for (int k = 0; k < len; k++) begin
      b.cyc  = n + 2 + k;
      b.data = in_range(s, k) ? mem_m[(s + k) % DEPTH] : '0;
      exp_q.push_back(b);
    end
    rstart    = 1'b1;
    raddr     = addr;
    rdata_len = LW'(len);
    step();
    rstart = 1'b0;
    if (len == 0) begin
      repeat (3) begin
        check("r_len0_ready", 64'(rready), 64'd1);
        step();
      end
      return;
    end
    while (cyc < n + 2 + len) begin
      check("r_busy", 64'(rready), 64'd0);
      step();
    end
    check("r_done_ready", 64'(rready), 64'd1);
    check("r_all_beats", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_cap(input string name, input int i, input logic [DW-1:0] exp);
    check(name, (cap_q.size() > i) ? cap_q[i] : 64'hx, exp);
  endtask

  initial begin
    int unsigned n;
    logic [DW-1:0] old0;
    logic [DW-1:0] old1;

    // Reset state and release
    step(3);
    check("rst_wready", 64'(wready), 64'd0);
    check("rst_rready", 64'(rready), 64'd0);
    check("rst_bound_err", 64'(bound_err), 64'd0);
    rstn = 1'b1;
    check("rel_wready_pre", 64'(wready), 64'd0);
    step();
    check("rel_wready", 64'(wready), 64'd1);
    check("rel_rready", 64'(rready), 64'd1);

    // Preload every entry so all reads are known
    do_write(32'h0, DEPTH, 0, '0, 1'b1);

    // Back-to-back write then read of 0xA0..0xA3
    do_write(32'h100, 4, 0, 64'hA0, 1'b0);
    cap_q.delete();
    do_read(32'h100, 4);
    for (int i = 0; i < 4; i++) check_cap("t2_data", i, 64'hA0 + 64'(i));

    // Gapped write, then a stray idle beat that must not land
    do_write(32'h40, 3, 100, 64'hB0, 1'b0);
    wdata_vld = 1'b1;
    wdata     = 64'hDEAD;
    step();
    wdata_vld = 1'b0;
    cap_q.delete();
    do_read(32'h40, 4);
    for (int i = 0; i < 3; i++) check_cap("t3_data", i, 64'hB0 + 64'(i));

    // Concurrent write and read over the same indices return prior contents
    cap_q.delete();
    fork
      do_write(32'h0, 8, 0, '0, 1'b1);
      do_read(32'h200, 8);
    join
    for (int i = 0; i < 4; i++) check_cap("t4_old_data", i, 64'hA0 + 64'(i));

    // Zero-length requests
    do_write(32'h80, 0, 0, '0, 1'b0);
    do_read(32'h80, 0);

    // Window crossing the end of memory
    old0 = mem_m[0];
    old1 = mem_m[1];
    do_write(32'h70, 4, 0, 64'h60, 1'b0);
    cap_q.delete();
    do_read(32'h70, 4);
    do_read(32'h0, 2);
    check_cap("t6_b0", 0, 64'h60);
    check_cap("t6_b1", 1, 64'h61);
`ifdef BRAM_DDR_RESP_BOUND_CHK_EN
    check_cap("t6_b2", 2, 64'h0);
    check_cap("t6_b3", 3, 64'h0);
    check_cap("t6_idx0", 4, old0);
    check_cap("t6_idx1", 5, old1);
    check("t6_bound_err", 64'(bound_err), 64'd1);
`else
    check_cap("t6_b2", 2, 64'h62);
    check_cap("t6_b3", 3, 64'h63);
    check_cap("t6_idx0", 4, 64'h62);
    check_cap("t6_idx1", 5, 64'h63);
    check("t6_bound_err", 64'(bound_err), 64'd0);
`endif

    // Reset asserted on beat 2 of an 8-beat read
    n = cyc;
    for (int k = 0; k < 8; k++) begin
      beat_t b;
      b.cyc  = n + 2 + k;
      b.data = mem_m[k];
      exp_q.push_back(b);
    end
    rstart    = 1'b1;
    raddr     = 32'h0;
    rdata_len = LW'(8);
    step();
    rstart = 1'b0;
    while (cyc < n + 4) step();
    rstn = 1'b0;
    exp_q.delete();
    last_exp  = '0;
    exp_bound = 1'b0;
    #1;
    check("t7_wready", 64'(wready), 64'd0);
    check("t7_rready", 64'(rready), 64'd0);
    check("t7_bound_err", 64'(bound_err), 64'd0);
    step(2);
    rstn = 1'b1;
    check("t7_rready_pre", 64'(rready), 64'd0);
    step();
    check("t7_wready_post", 64'(wready), 64'd1);
    check("t7_rready_post", 64'(rready), 64'd1);

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      int op;
      logic [AW-1:0] a;
      int len;
      op  = int'($urandom_range(2));
      a   = AW'($urandom_range(0, 1023));
      len = int'($urandom_range(0, 20));
      case (op)
        0: do_write(a, len, int'($urandom_range(0, 50)), '0, 1'b1);
        1: do_read(a, len);
        default: begin
          len = int'($urandom_range(1, DEPTH));
          fork
            do_write(a, len, int'($urandom_range(0, 50)), '0, 1'b1);
            do_read(a, len);
          join
        end
      endcase
      check("bound_err", 64'(bound_err), 64'(exp_bound));
    end

    step(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
